// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-beat command port to APB4 master with one-hot PSELx decode.
// Optional ACCESS wait-state timeout is enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned NO_OF_SLAVES   = 16,
  parameter int unsigned ADDRESS_LENGTH = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned SEL_W          = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [SEL_W-1:0]          cmd_sel,
  input  logic [ADDRESS_LENGTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic [NO_OF_SLAVES-1:0]   pselx,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDRESS_LENGTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [2:0]                pprot,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE_STATE   = 2'd0,
    SETUP_STATE  = 2'd1,
    ACCESS_STATE = 2'd2
  } operation_states_e;

  typedef struct packed {
    logic [NO_OF_SLAVES-1:0]   pselx;
    logic                      penable;
    logic                      pwrite;
    logic [ADDRESS_LENGTH-1:0] paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [STRB_W-1:0]         pstrb;
    logic [2:0]                pprot;
  } apb_transfer_char_s;

  operation_states_e  state_q, state_d;
  apb_transfer_char_s apb_q, apb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  err_pend_q, err_pend_d;
  logic                  accept;
  logic                  decode_err;

  assign cmd_ready  = (state_q == IDLE_STATE) | ((state_q == ACCESS_STATE) & pready);
  assign accept     = cmd_valid & cmd_ready;
  assign decode_err = 32'(cmd_sel) >= NO_OF_SLAVES;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // The wait-state limit has no effect unless the timeout feature is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout_unsupported
  end
`endif

  // Next-state, APB payload and response generation.
  always_comb begin
    state_d      = state_q;
    apb_d        = apb_q;
    rsp_valid_d  = 1'b0;
    rsp_slverr_d = 1'b0;
    rsp_rdata_d  = '0;
    err_pend_d   = err_pend_q;
`ifdef APB_BRIDGE_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      SETUP_STATE: begin
        state_d       = ACCESS_STATE;
        apb_d.penable = 1'b1;
      end
      ACCESS_STATE: begin
        if (pready) begin
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = pslverr;
          rsp_rdata_d   = (apb_q.pwrite | pslverr) ? '0 : prdata;
          state_d       = IDLE_STATE;
          apb_d.pselx   = '0;
          apb_d.penable = 1'b0;
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        else if (timeout) begin
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          state_d       = IDLE_STATE;
          apb_d.pselx   = '0;
          apb_d.penable = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: ;
    endcase

    // A decode error accepted alongside a completion is answered one cycle later.
    if (err_pend_q && !rsp_valid_d) begin
      rsp_valid_d  = 1'b1;
      rsp_slverr_d = 1'b1;
      err_pend_d   = 1'b0;
    end

    if (accept) begin
      if (decode_err) begin
        if (rsp_valid_d) begin
          err_pend_d = 1'b1;
        end else begin
          rsp_valid_d  = 1'b1;
          rsp_slverr_d = 1'b1;
        end
      end else begin
        state_d       = SETUP_STATE;
        apb_d.pselx   = NO_OF_SLAVES'(1) << cmd_sel;
        apb_d.penable = 1'b0;
        apb_d.pwrite  = cmd_write;
        apb_d.paddr   = cmd_addr;
        apb_d.pwdata  = cmd_wdata;
        apb_d.pstrb   = cmd_write ? cmd_strb : '0;
        apb_d.pprot   = cmd_prot;
`ifdef APB_BRIDGE_TIMEOUT_EN
        cnt_d         = '0;
`endif
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q      <= IDLE_STATE;
      apb_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_slverr_q <= 1'b0;
      rsp_rdata_q  <= '0;
      err_pend_q   <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      apb_q        <= apb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_slverr_q <= rsp_slverr_d;
      rsp_rdata_q  <= rsp_rdata_d;
      err_pend_q   <= err_pend_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign pselx      = apb_q.pselx;
  assign penable    = apb_q.penable;
  assign pwrite     = apb_q.pwrite;
  assign paddr      = apb_q.paddr;
  assign pwdata     = apb_q.pwdata;
  assign pstrb      = apb_q.pstrb;
  assign pprot      = apb_q.pprot;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_slverr = rsp_slverr_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed and random stimulus against a transaction-age model
// of the APB bridge; honours APB_BRIDGE_TIMEOUT_EN when defined.
module tb_apb_master_bridge;

  localparam int unsigned NS   = 6;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 64;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned TMO  = 16;
  localparam int unsigned SELW = 3;

  logic            pclk;
  logic            preset_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [SELW-1:0] cmd_sel;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [SW-1:0]   cmd_strb;
  logic [2:0]      cmd_prot;
  logic            rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_slverr;
  logic [NS-1:0]   pselx;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [2:0]      pprot;
  logic            pready;
  logic [DW-1:0]   prdata;
  logic            pslverr;

  apb_master_bridge #(
    .NO_OF_SLAVES  (NS),
    .ADDRESS_LENGTH(AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO),
    .SEL_W         (SELW)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_sel   (cmd_sel),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_slverr(rsp_slverr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Model: a transfer is tracked by its age in cycles since the accepting edge.
  bit            m_busy;
  int            m_age;
  int            m_owed;
  logic [NS-1:0] e_psel;
  logic          e_pen, e_pwrite, e_rv, e_rerr;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata, e_rdata;
  logic [SW-1:0] e_pstrb;
  logic [2:0]    e_pprot;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_owed = 0;
    e_psel = '0; e_pen = 0; e_pwrite = 0; e_rv = 0; e_rerr = 0;
    e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_pstrb = '0; e_pprot = '0;
  endtask

  function automatic bit model_ready();
    return !m_busy || (m_age >= 2 && pready === 1'b1);
  endfunction

  task automatic model_update();
    bit acc, bad, slot;
    acc  = (cmd_valid === 1'b1) && model_ready();
    bad  = int'(cmd_sel) >= int'(NS);
    slot = 0;
    e_rv = 0; e_rerr = 0; e_rdata = '0;
    if (m_busy && m_age >= 2) begin
      if (pready) begin
        e_rv = 1; e_rerr = pslverr;
        e_rdata = (e_pwrite || pslverr) ? '0 : prdata;
        slot = 1; m_busy = 0;
      end
`ifdef APB_BRIDGE_TIMEOUT_EN
      else if (m_age - 1 == int'(TMO)) begin
        e_rv = 1; e_rerr = 1; slot = 1; m_busy = 0;
      end
`endif
    end
    if (acc && bad) m_owed++;
    if (!slot && m_owed > 0) begin
      e_rv = 1; e_rerr = 1; m_owed--;
    end
    if (acc && !bad) begin
      m_busy = 1; m_age = 0;
      e_psel = NS'(1) << cmd_sel;
      e_pwrite = cmd_write; e_paddr = cmd_addr; e_pwdata = cmd_wdata;
      e_pstrb = cmd_write ? cmd_strb : '0; e_pprot = cmd_prot;
    end
    if (m_busy) m_age++;
    e_pen = m_busy && m_age >= 2;
    if (!m_busy) e_psel = '0;
  endtask

  task automatic compare_all();
    chk("pselx", 64'(pselx), 64'(e_psel));
    chk("penable", 64'(penable), 64'(e_pen));
    chk("pwrite", 64'(pwrite), 64'(e_pwrite));
    chk("paddr", 64'(paddr), 64'(e_paddr));
    chk("pwdata", pwdata, e_pwdata);
    chk("pstrb", 64'(pstrb), 64'(e_pstrb));
    chk("pprot", 64'(pprot), 64'(e_pprot));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_slverr", 64'(rsp_slverr), 64'(e_rerr));
    chk("rsp_rdata", rsp_rdata, e_rdata);
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic step();
    #1 chk("cmd_ready", 64'(cmd_ready), 64'(model_ready()));
    @(posedge pclk);
    model_update();
    @(negedge pclk);
    compare_all();
  endtask

  task automatic do_reset();
    cmd_valid = 0;
    #2 preset_n = 0;
    #1;
    chk("rst_pselx", 64'(pselx), 64'h0);
    chk("rst_penable", 64'(penable), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_paddr", 64'(paddr), 64'h0);
    chk("rst_pwdata", pwdata, 64'h0);
    model_reset();
    @(negedge pclk);
    compare_all();
    preset_n = 1;
  endtask

  task automatic set_cmd(input bit wr, input int sel, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_valid = 1; cmd_write = wr; cmd_sel = SELW'(sel);
    cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = 3'b010;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset_n = 0; cmd_valid = 0; cmd_write = 0; cmd_sel = '0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    pready = 1; prdata = '0; pslverr = 0;
    model_reset();
    @(negedge pclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("rst_pselx", 64'(pselx), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    compare_all();
    preset_n = 1;

    // Zero-wait write to slave 2.
    set_cmd(1, 2, 32'h10, 64'hA5A5, 8'hFF);
    step();
    chk("wr_setup_psel", 64'(pselx), 64'h04);
    chk("wr_setup_penable", 64'(penable), 64'h0);
    cmd_valid = 0;
    step();
    chk("wr_access_penable", 64'(penable), 64'h1);
    step();
    chk("wr_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("wr_rsp_slverr", 64'(rsp_slverr), 64'h0);
    chk("wr_rsp_rdata", rsp_rdata, 64'h0);
    chk("wr_idle_psel", 64'(pselx), 64'h0);
    chk("wr_paddr_kept", 64'(paddr), 64'h10);

    // Read from slave 0 with three wait states.
    set_cmd(0, 0, 32'h20, 64'h1234, 8'hFF);
    pready = 0;
    step();
    cmd_valid = 0;
    chk("rd_pstrb_setup", 64'(pstrb), 64'h0);
    for (int k = 0; k < 4; k++) begin
      pready = 0;
      step();
      chk("rd_paddr_stable", 64'(paddr), 64'h20);
      chk("rd_pstrb_access", 64'(pstrb), 64'h0);
    end
    pready = 1; prdata = 64'hDEAD_BEEF;
    step();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("rd_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF);

    // Back-to-back commands.
    set_cmd(1, 1, 32'h30, 64'h1, 8'h0F);
    step();
    set_cmd(1, 3, 32'h34, 64'h2, 8'hF0);
    step();
    chk("b2b_access1", 64'(penable), 64'h1);
    step();
    chk("b2b_setup2_psel", 64'(pselx), 64'h08);
    chk("b2b_setup2_penable", 64'(penable), 64'h0);
    chk("b2b_rsp1", 64'(rsp_valid), 64'h1);
    cmd_valid = 0;
    step();
    chk("b2b_gap", 64'(rsp_valid), 64'h0);
    step();
    chk("b2b_rsp2", 64'(rsp_valid), 64'h1);

    // Decode error.
    set_cmd(0, 7, 32'h40, 64'h0, 8'h0);
    step();
    cmd_valid = 0;
    chk("dec_psel", 64'(pselx), 64'h0);
    chk("dec_penable", 64'(penable), 64'h0);
    chk("dec_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("dec_rsp_slverr", 64'(rsp_slverr), 64'h1);
    chk("dec_rsp_rdata", rsp_rdata, 64'h0);

    // Completer error on a read.
    set_cmd(0, 5, 32'h50, 64'h0, 8'hFF);
    step();
    cmd_valid = 0; pslverr = 1; prdata = 64'h5555;
    chk("err_psel", 64'(pselx), 64'h20);
    step();
    step();
    chk("err_rsp_slverr", 64'(rsp_slverr), 64'h1);
    chk("err_rsp_rdata", rsp_rdata, 64'h0);
    pslverr = 0;

    // Reset during ACCESS.
    set_cmd(1, 4, 32'h60, 64'h77, 8'hFF);
    pready = 0;
    step();
    cmd_valid = 0;
    step();
    do_reset();
    pready = 1;
    step();
    chk("abort_no_rsp", 64'(rsp_valid), 64'h0);

    // Long stall on a read.
    set_cmd(0, 1, 32'h70, 64'h0, 8'h0);
    pready = 0;
    step();
    cmd_valid = 0;
`ifdef APB_BRIDGE_TIMEOUT_EN
    for (int k = 0; k < int'(TMO); k++) step();
    chk("tmo_still_access", 64'(penable), 64'h1);
    step();
    chk("tmo_psel", 64'(pselx), 64'h0);
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("tmo_rsp_slverr", 64'(rsp_slverr), 64'h1);
    pready = 1;
`else
    for (int k = 0; k < 100; k++) step();
    chk("stall_penable", 64'(penable), 64'h1);
    chk("stall_psel", 64'(pselx), 64'h02);
    pready = 1; prdata = 64'h0123_4567_89AB_CDEF;
    step();
    chk("stall_rsp_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_write = $urandom_range(0, 1) == 1;
        cmd_sel   = SELW'($urandom_range(0, 7));
        cmd_addr  = $urandom();
        cmd_wdata = {$urandom(), $urandom()};
        cmd_strb  = SW'($urandom());
        cmd_prot  = 3'($urandom());
        pready    = ($urandom_range(0, 3) != 0);
        pslverr   = ($urandom_range(0, 3) == 0);
        prdata    = {$urandom(), $urandom()};
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
